// File: rtl/seq_divider_56.sv
// rtl/seq_divider_56.sv - sequential restoring unsigned divider, one quotient bit per cycle
module seq_divider_56 #(
    parameter int mul_size = 56
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [mul_size-1:0] a,
    input  logic [mul_size-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [mul_size-1:0] q,
    output logic [mul_size-1:0] r,
    output logic                dbz
);

    localparam int CW = (mul_size > 1) ? $clog2(mul_size) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [mul_size-1:0] dvd;
    logic [mul_size-1:0] dvs;
    logic [mul_size-1:0] quo;
    logic [mul_size:0]   rem;

    // One extra remainder bit keeps the shifted value from overflowing when
    // the divisor is close to 2^mul_size.
    logic [mul_size:0]   rem_sh;
    logic [mul_size:0]   rem_sub;
    logic [mul_size:0]   rem_nxt;
    logic [mul_size-1:0] quo_nxt;
    logic                qbit;

    // Restoring step: shift in next dividend bit, subtract divisor when it fits.
    always_comb begin
        rem_sh  = (rem << 1) | {{mul_size{1'b0}}, dvd[mul_size-1]};
        rem_sub = rem_sh - {1'b0, dvs};
        qbit    = (rem_sh >= {1'b0, dvs});
        rem_nxt = qbit ? rem_sub : rem_sh;
        quo_nxt = (quo << 1) | {{(mul_size-1){1'b0}}, qbit};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start only matters outside RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (b == '0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dvd <= '0;
            dvs <= '0;
            quo <= '0;
            rem <= '0;
            q   <= '0;
            r   <= '0;
            dbz <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (b == '0) begin
                            q   <= '1;
                            r   <= a;
                            dbz <= 1'b1;
                        end else begin
                            dvd <= a;
                            dvs <= b;
                            quo <= '0;
                            rem <= '0;
                            cnt <= CW'(mul_size - 1);
                        end
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    dvd <= dvd << 1;
                    if (cnt == '0) begin
                        q   <= quo_nxt;
                        r   <= rem_nxt[mul_size-1:0];
                        dbz <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
